// File: rtl/zloader_if.sv
// Byte-stream handshake between a boot source and the zloader.
// A byte transfers on a rising edge when IN_VALID and IN_READY are both high.
interface zloader_if #(
  parameter int DATA_W = 8
);
  logic              IN_VALID;
  logic [DATA_W-1:0] IN_DATA;
  logic              IN_READY;

  modport master (output IN_VALID, output IN_DATA, input IN_READY);
  modport slave  (input IN_VALID, input IN_DATA, output IN_READY);
endinterface

// File: rtl/zloader.sv
// Boot-time program loader: frames LEN/payload/CHK into program RAM, then releases the core.
// Optional: define ZLOADER_ZERO_FILL_EN to pad unused RAM words with 0x00 before RUN.
module zloader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  zloader_if.slave          in_if,
  input  logic              RELOAD,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_OP,
  output logic [DATA_W-1:0] RAM_DATA_IN,
  output logic              CORE_RESET,
  output logic              DONE,
  output logic              ERROR,
  output logic [ADDR_W:0]   BYTE_COUNT
);

  // state   | meaning
  // S_IDLE  | waiting for LEN byte
  // S_LOAD  | writing payload bytes to RAM
  // S_CHECK | waiting for checksum byte
  // S_RUN   | core released, core owns RAM
  // S_ERR   | bad length or checksum, wait for RELOAD
  // S_FILL  | zero-padding addresses LEN..DEPTH-1 (optional)
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4,
    S_FILL  = 3'd5
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
  localparam logic [DATA_W-1:0] DEPTH_B = DATA_W'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              run_q, run_d;
`ifdef ZLOADER_ZERO_FILL_EN
  logic [ADDR_W-1:0] fill_q, fill_d;
`endif

  logic            ready;
  logic            accept;
  logic [ADDR_W:0] count_inc;

  assign ready          = (state_q inside {S_IDLE, S_LOAD, S_CHECK}) && !RELOAD;
  assign in_if.IN_READY = ready;
  assign accept         = in_if.IN_VALID && ready;
  assign count_inc      = count_q + ONE_C;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    op_d    = 1'b0;
    wdata_d = wdata_q;
`ifdef ZLOADER_ZERO_FILL_EN
    fill_d  = fill_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_if.IN_DATA == '0 || in_if.IN_DATA > DEPTH_B) begin
            state_d = S_ERR;
          end else begin
            len_d   = in_if.IN_DATA[ADDR_W:0];
            sum_d   = '0;
            count_d = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          op_d    = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          wdata_d = in_if.IN_DATA;
          sum_d   = sum_q + in_if.IN_DATA;
          count_d = count_inc;
          if (count_inc == len_q) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (in_if.IN_DATA != sum_q) begin
            state_d = S_ERR;
          end else begin
`ifdef ZLOADER_ZERO_FILL_EN
            if (len_q != DEPTH_C) begin
              fill_d  = len_q[ADDR_W-1:0];
              state_d = S_FILL;
            end else begin
              addr_d  = '0;
              state_d = S_RUN;
            end
`else
            addr_d  = '0;
            state_d = S_RUN;
`endif
          end
        end
      end
`ifdef ZLOADER_ZERO_FILL_EN
      S_FILL: begin
        // Last pad write keeps its address; RUN parks RAM_ADDR at 0 one cycle later.
        op_d    = 1'b1;
        addr_d  = fill_q;
        wdata_d = '0;
        fill_d  = fill_q + 1'b1;
        if (fill_q == ADDR_W'(DEPTH - 1)) state_d = S_RUN;
      end
`endif
      S_RUN: begin
        addr_d = '0;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (RELOAD) begin
      state_d = S_IDLE;
      op_d    = 1'b0;
      count_d = '0;
      len_d   = '0;
      sum_d   = '0;
    end

    // Core release lags the RUN transition by one edge and drops on the edge that leaves RUN.
    run_d = (state_q == S_RUN) && (state_d == S_RUN);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      count_q <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      op_q    <= 1'b0;
      wdata_q <= '0;
      run_q   <= 1'b0;
`ifdef ZLOADER_ZERO_FILL_EN
      fill_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
`ifdef ZLOADER_ZERO_FILL_EN
      fill_q  <= fill_d;
`endif
    end
  end

  assign RAM_ADDR    = addr_q;
  assign RAM_OP      = op_q;
  assign RAM_DATA_IN = wdata_q;
  assign CORE_RESET  = !run_q;
  assign DONE        = run_q;
  assign ERROR       = (state_q == S_ERR);
  assign BYTE_COUNT  = count_q;

endmodule

// File: tb/tb_zloader.sv
// Self-checking bench for zloader: RAM writes are scored against a queue of expected addr/data.
// Compile with ZLOADER_ZERO_FILL_EN defined to also cover zero padding.
module tb_zloader;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       RELOAD = 1'b0;
  logic [3:0] RAM_ADDR;
  logic       RAM_OP;
  logic [7:0] RAM_DATA_IN;
  logic       CORE_RESET;
  logic       DONE;
  logic       ERROR;
  logic [4:0] BYTE_COUNT;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  zloader_if #(.DATA_W(8)) s_if ();

  zloader #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .in_if(s_if), .RELOAD(RELOAD),
    .RAM_ADDR(RAM_ADDR), .RAM_OP(RAM_OP), .RAM_DATA_IN(RAM_DATA_IN),
    .CORE_RESET(CORE_RESET), .DONE(DONE), .ERROR(ERROR), .BYTE_COUNT(BYTE_COUNT)
  );

  always #5 CLK = ~CLK;

  // Every cycle with RAM_OP high must match the next expected write.
  always @(negedge CLK) begin
    if (RAM_OP === 1'b1) begin
      logic [11:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ram_write unexpected: got addr=%0h data=%0h, required no write", RAM_ADDR, RAM_DATA_IN);
      end else begin
        e = exp_q.pop_front();
        if ({RAM_ADDR, RAM_DATA_IN} !== e) begin
          errors++;
          $display("FAIL ram_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   RAM_ADDR, RAM_DATA_IN, e[11:8], e[7:0]);
        end
      end
    end
  end

  task automatic push_w(input logic [3:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic push_fill(input int len);
`ifdef ZLOADER_ZERO_FILL_EN
    for (int i = len; i < 16; i++) push_w(4'(i), 8'h00);
`endif
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n;
    @(negedge CLK);
    s_if.IN_VALID = 1'b1;
    s_if.IN_DATA  = d;
    n = 0;
    #1;
    while (s_if.IN_READY !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h not accepted, IN_READY=%b required 1", d, s_if.IN_READY);
    end else begin
      @(posedge CLK);
    end
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    s_if.IN_VALID = 1'b0;
    s_if.IN_DATA  = 8'($urandom);
  endtask

  task automatic check_drain(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d writes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic expect_done(input string name);
`ifdef ZLOADER_ZERO_FILL_EN
    int n;
    idle_cycle();
    n = 0;
    while (DONE !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (DONE !== 1'b1 || CORE_RESET !== 1'b0) begin
      errors++;
      $display("FAIL %s done: DONE=%b CORE_RESET=%b, required 1 0", name, DONE, CORE_RESET);
    end
`else
    idle_cycle();
    checks++;
    if (DONE !== 1'b0 || CORE_RESET !== 1'b1) begin
      errors++;
      $display("FAIL %s done_early: DONE=%b CORE_RESET=%b, required 0 1", name, DONE, CORE_RESET);
    end
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b1 || CORE_RESET !== 1'b0 || s_if.IN_READY !== 1'b0 || RAM_OP !== 1'b0 || RAM_ADDR !== 4'h0) begin
      errors++;
      $display("FAIL %s run: DONE=%b CORE_RESET=%b IN_READY=%b RAM_OP=%b RAM_ADDR=%0h, required 1 0 0 0 0",
               name, DONE, CORE_RESET, s_if.IN_READY, RAM_OP, RAM_ADDR);
    end
`endif
  endtask

  task automatic reload_pulse();
    @(negedge CLK);
    RELOAD = 1'b1;
    s_if.IN_VALID = 1'b0;
    @(negedge CLK);
    RELOAD = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (s_if.IN_READY !== 1'b1 || RAM_ADDR !== 4'h0 || RAM_OP !== 1'b0 || RAM_DATA_IN !== 8'h00 ||
        CORE_RESET !== 1'b1 || DONE !== 1'b0 || ERROR !== 1'b0 || BYTE_COUNT !== 5'd0) begin
      errors++;
      $display("FAIL %s: rdy=%b addr=%0h op=%b din=%0h crst=%b done=%b err=%b cnt=%0d, required 1 0 0 0 1 0 0 0",
               name, s_if.IN_READY, RAM_ADDR, RAM_OP, RAM_DATA_IN, CORE_RESET, DONE, ERROR, BYTE_COUNT);
    end
  endtask

  task automatic test_reset();
    s_if.IN_VALID = 1'b0;
    s_if.IN_DATA  = 8'h00;
    repeat (3) @(negedge CLK);
    check_reset_vals("reset_held");
    RESET = 1'b0;
    @(negedge CLK);
    check_reset_vals("reset_released");
  endtask

  task automatic test_good_frame();
    logic [7:0] p[3] = '{8'h44, 8'h8E, 8'h00};
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 3; i++) begin
      push_w(4'(i), p[i]);
      s += p[i];
    end
    push_fill(3);
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) send_byte(p[i]);
    send_byte(s);
    expect_done("good_frame");
    check_drain("good_frame");
    reload_pulse();
    #1;
    checks++;
    if (DONE !== 1'b0 || CORE_RESET !== 1'b1 || s_if.IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL reload_from_run: DONE=%b CORE_RESET=%b IN_READY=%b, required 0 1 1", DONE, CORE_RESET, s_if.IN_READY);
    end
  endtask

  task automatic test_bad_chk();
    push_w(4'h0, 8'h10);
    push_w(4'h1, 8'h20);
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h31);
    idle_cycle();
    repeat (2) @(negedge CLK);
    checks++;
    if (ERROR !== 1'b1 || CORE_RESET !== 1'b1 || s_if.IN_READY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL bad_chk: ERROR=%b CORE_RESET=%b IN_READY=%b DONE=%b, required 1 1 0 0",
               ERROR, CORE_RESET, s_if.IN_READY, DONE);
    end
    check_drain("bad_chk");
    reload_pulse();
    #1;
    checks++;
    if (ERROR !== 1'b0 || s_if.IN_READY !== 1'b1 || BYTE_COUNT !== 5'd0) begin
      errors++;
      $display("FAIL bad_chk_reload: ERROR=%b IN_READY=%b BYTE_COUNT=%0d, required 0 1 0", ERROR, s_if.IN_READY, BYTE_COUNT);
    end
  endtask

  task automatic test_bad_len();
    logic [7:0] lens[2] = '{8'h00, 8'h11};
    for (int i = 0; i < 2; i++) begin
      send_byte(lens[i]);
      idle_cycle();
      checks++;
      if (ERROR !== 1'b1 || s_if.IN_READY !== 1'b0 || RAM_OP !== 1'b0) begin
        errors++;
        $display("FAIL bad_len %0h: ERROR=%b IN_READY=%b RAM_OP=%b, required 1 0 0", lens[i], ERROR, s_if.IN_READY, RAM_OP);
      end
      repeat (2) @(negedge CLK);
      reload_pulse();
    end
    check_drain("bad_len");
  endtask

  task automatic test_full_wrap();
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 16; i++) begin
      push_w(4'(i), 8'hFF);
      s += 8'hFF;
    end
    send_byte(8'h10);
    idle_cycle();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'hFF);
      idle_cycle();
    end
    checks++;
    if (BYTE_COUNT !== 5'd16 || s !== 8'hF0) begin
      errors++;
      $display("FAIL full_count: BYTE_COUNT=%0d chk=%0h, required 16 f0", BYTE_COUNT, s);
    end
    send_byte(s);
    expect_done("full_wrap");
    check_drain("full_wrap");
    reload_pulse();
  endtask

  task automatic test_reload_mid();
    push_w(4'h0, 8'h5A);
    send_byte(8'h03);
    send_byte(8'h5A);
    @(negedge CLK);
    RELOAD = 1'b1;
    s_if.IN_VALID = 1'b1;
    s_if.IN_DATA  = 8'h77;
    #1;
    checks++;
    if (s_if.IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL reload_ready: IN_READY=%b, required 0", s_if.IN_READY);
    end
    @(negedge CLK);
    RELOAD = 1'b0;
    s_if.IN_VALID = 1'b0;
    #1;
    checks++;
    if (BYTE_COUNT !== 5'd0 || s_if.IN_READY !== 1'b1 || RAM_OP !== 1'b0) begin
      errors++;
      $display("FAIL reload_mid: BYTE_COUNT=%0d IN_READY=%b RAM_OP=%b, required 0 1 0", BYTE_COUNT, s_if.IN_READY, RAM_OP);
    end
    check_drain("reload_mid");
  endtask

  task automatic test_reset_mid();
    push_w(4'h0, 8'h11);
    push_w(4'h1, 8'h22);
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    idle_cycle();
    #2;
    RESET = 1'b1;
    #1;
    check_reset_vals("reset_mid");
    check_drain("reset_mid_partial");
    @(negedge CLK);
    RESET = 1'b0;
    push_w(4'h0, 8'h55);
    push_fill(1);
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h55);
    expect_done("after_reset");
    check_drain("after_reset");
    reload_pulse();
  endtask

`ifdef ZLOADER_ZERO_FILL_EN
  task automatic test_zero_fill();
    push_w(4'h0, 8'h01);
    push_w(4'h1, 8'h02);
    push_fill(2);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    idle_cycle();
    for (int a = 2; a < 16; a++) begin
      @(negedge CLK);
      checks++;
      if (RAM_OP !== 1'b1 || RAM_ADDR !== 4'(a) || CORE_RESET !== 1'b1) begin
        errors++;
        $display("FAIL fill_cycle: RAM_OP=%b RAM_ADDR=%0h CORE_RESET=%b, required 1 %0h 1", RAM_OP, RAM_ADDR, CORE_RESET, a);
      end
    end
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b1 || RAM_OP !== 1'b0) begin
      errors++;
      $display("FAIL fill_done: DONE=%b RAM_OP=%b, required 1 0", DONE, RAM_OP);
    end
    check_drain("zero_fill");
    reload_pulse();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_bad_len();
    test_full_wrap();
    test_reload_mid();
    test_reset_mid();
`ifdef ZLOADER_ZERO_FILL_EN
    test_zero_fill();
`endif
    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
